// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard scoreboard.
// Register index width, producer latency classes and default latencies.
package hazard_scoreboard_pkg;

    localparam int REG_W      = 5;
    localparam int MD_LAT_DEF = 4;
    localparam int LD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        LAT_ALU    = 2'd0,
        LAT_LOAD   = 2'd1,
        LAT_MULDIV = 2'd2
    } latClass_e;

endpackage

// File: rtl/hazard_scoreboard_countdown.sv
// Single load/decrement countdown used per tracked register and for MUL/DIV.
// A load takes priority over the decrement in the same cycle.
module reg_countdown #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] loadVal,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Producer-side scoreboard: tracks in-flight writes and stalls ID when an
// operand is not yet forwardable, a WAW would reorder, or MUL/DIV is busy.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int MD_LAT = MD_LAT_DEF,
    parameter int LD_LAT = LD_LAT_DEF,
    parameter int CW     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_kill,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_write_reg,
    input  logic             id_RegWr,
    input  logic             id_MemRead,
    input  logic             id_muldiv,
    output logic             stall,
    output logic             bubble,
    output logic             md_busy,
    output logic [31:0]      pending
);

    logic [CW-1:0] cnt [32];
    logic [CW-1:0] mdCnt;
    logic [CW-1:0] lat;
    latClass_e     latClass;
    logic          rawHit;
    logic          wawHit;
    logic          mdHit;
    logic          issue;

    // MUL/DIV dominates when both class bits are set
    always_comb begin
        latClass = LAT_ALU;
        priority case (1'b1)
            id_muldiv:  latClass = LAT_MULDIV;
            id_MemRead: latClass = LAT_LOAD;
            default:    latClass = LAT_ALU;
        endcase
    end

    always_comb begin
        lat = '0;
        case (latClass)
            LAT_MULDIV: lat = CW'(MD_LAT);
            LAT_LOAD:   lat = CW'(LD_LAT);
            default:    lat = '0;
        endcase
    end

    assign rawHit = (id_use_rs && cnt[id_rs] != '0)
                 || (id_use_rt && cnt[id_rt] != '0);
    assign wawHit = id_RegWr && id_write_reg != '0
                 && cnt[id_write_reg] > lat;
    assign mdHit  = id_muldiv && mdCnt != '0;

    assign stall  = id_valid && !id_kill && (rawHit || wawHit || mdHit);
    assign bubble = stall;
    assign issue  = id_valid && !id_kill && !stall;

    assign cnt[0] = '0;

    for (genvar r = 1; r < 32; r++) begin : gReg
        reg_countdown #(.CW(CW)) uCnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (issue && id_RegWr && lat != '0
                      && id_write_reg == REG_W'(r)),
            .loadVal (lat),
            .count   (cnt[r])
        );
    end

    reg_countdown #(.CW(CW)) uMdCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (issue && id_muldiv),
        .loadVal (CW'(MD_LAT)),
        .count   (mdCnt)
    );

    assign md_busy = mdCnt != '0;

    always_comb begin
        pending = '0;
        for (int r = 0; r < 32; r++) begin
            pending[r] = cnt[r] != '0;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard (MD_LAT=4, LD_LAT=1).
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_kill;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  id_write_reg;
    logic        id_RegWr;
    logic        id_MemRead;
    logic        id_muldiv;
    logic        stall;
    logic        bubble;
    logic        md_busy;
    logic [31:0] pending;

    typedef struct {
        string       tag;
        logic        st;
        logic        busy;
        logic [31:0] pend;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    hazard_scoreboard #(.MD_LAT(4), .LD_LAT(1), .CW(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_kill      (id_kill),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_write_reg (id_write_reg),
        .id_RegWr     (id_RegWr),
        .id_MemRead   (id_MemRead),
        .id_muldiv    (id_muldiv),
        .stall        (stall),
        .bubble       (bubble),
        .md_busy      (md_busy),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            chk({e.tag, ".stall"}, 32'(stall), 32'(e.st));
            chk({e.tag, ".bubble"}, 32'(bubble), 32'(e.st));
            chk({e.tag, ".busy"}, 32'(md_busy), 32'(e.busy));
            chk({e.tag, ".pend"}, pending, e.pend);
        end
    end

    // one ID cycle: drive after the edge, queue what must be seen mid-cycle
    task automatic step(input string tag, input logic v, input logic k,
                        input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt,
                        input logic [4:0] wr, input logic rw,
                        input logic mr, input logic md,
                        input logic est, input logic ebusy,
                        input logic [31:0] epend);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid     = v;
        id_kill      = k;
        id_rs        = rs;
        id_use_rs    = urs;
        id_rt        = rt;
        id_use_rt    = urt;
        id_write_reg = wr;
        id_RegWr     = rw;
        id_MemRead   = mr;
        id_muldiv    = md;
        e.tag  = tag;
        e.st   = est;
        e.busy = ebusy;
        e.pend = epend;
        expQ.push_back(e);
    endtask

    task automatic idle(input string tag, input logic ebusy,
                        input logic [31:0] epend);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ebusy, epend);
    endtask

    localparam logic [31:0] B3  = 32'h1 << 3;
    localparam logic [31:0] B8  = 32'h1 << 8;
    localparam logic [31:0] B10 = 32'h1 << 10;
    localparam logic [31:0] B11 = 32'h1 << 11;
    localparam logic [31:0] B12 = 32'h1 << 12;

    initial begin
        rst_n        = 1'b0;
        id_valid     = 0;
        id_kill      = 0;
        id_rs        = 0;
        id_rt        = 0;
        id_use_rs    = 0;
        id_use_rt    = 0;
        id_write_reg = 0;
        id_RegWr     = 0;
        id_MemRead   = 0;
        id_muldiv    = 0;
        #2;
        chk("rst.stall", 32'(stall), 0);
        chk("rst.busy", 32'(md_busy), 0);
        chk("rst.pend", pending, 0);
        rst_n = 1'b1;

        // load-use: one stall cycle
        step("ld", 1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0);
        step("use0", 1, 0, 8, 1, 0, 0, 9, 1, 0, 0, 1, 0, B8);
        step("use1", 1, 0, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
        idle("ldIdle", 0, 0);

        // ALU chain: no stall
        step("add", 1, 0, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0);
        step("sub", 1, 0, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0);

        // muldiv RAW: four stall cycles
        step("md", 1, 0, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0, 0);
        for (int i = 4; i >= 1; i--)
            step($sformatf("mdRaw%0d", i), 1, 0, 10, 1, 0, 0, 13, 1, 0, 0,
                 1, 1, B10);
        step("mdRawGo", 1, 0, 10, 1, 0, 0, 13, 1, 0, 0, 0, 0, 0);

        // back-to-back muldiv: structural stall
        step("mdA", 1, 0, 0, 0, 0, 0, 11, 1, 0, 1, 0, 0, 0);
        for (int i = 4; i >= 1; i--)
            step($sformatf("mdB%0d", i), 1, 0, 1, 1, 0, 0, 12, 1, 0, 1,
                 1, 1, B11);
        step("mdBGo", 1, 0, 1, 1, 0, 0, 12, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            idle($sformatf("mdBDrain%0d", i), 1, B12);
        idle("mdBDone", 0, 0);

        // WAW: ALU write to r3 waits for the muldiv count to drain
        step("wawMd", 1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
        for (int i = 4; i >= 1; i--)
            step($sformatf("waw%0d", i), 1, 0, 0, 0, 0, 0, 3, 1, 0, 0,
                 1, 1, B3);
        step("wawGo", 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        idle("wawIdle", 0, 0);

        // register 0 is never tracked
        step("ldR0", 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("useR0", 1, 0, 0, 1, 0, 1, 7, 1, 0, 0, 0, 0, 0);

        // kill suppresses stall and the killed load's count
        step("ldK", 1, 0, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0);
        step("kill", 1, 1, 8, 1, 0, 0, 20, 1, 1, 0, 0, 0, B8);
        idle("killIdle", 0, 0);

        // asynchronous reset while r10 and md_cnt are at 3
        step("rMd", 1, 0, 0, 0, 0, 0, 10, 1, 0, 1, 0, 0, 0);
        idle("rIdle", 1, B10);
        step("rUse", 1, 0, 10, 1, 0, 0, 14, 1, 0, 0, 1, 1, B10);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.pend", pending, 0);
        chk("arst.busy", 32'(md_busy), 0);
        chk("arst.stall", 32'(stall), 0);
        rst_n = 1'b1;
        step("postRst", 1, 0, 10, 1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
        idle("end", 0, 0);

        repeat (2) @(posedge clk);
        chk("queueEmpty", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
